// File: rtl/core_pkg.sv
// Shared constants for the core instruction sequencer: opcodes, inst-word bit map,
// MAC codes and the payload carried by the one-stage delay pipe.
package core_pkg;

    localparam int INST_W     = 20;
    localparam int INST_ADD_W = 4;

    localparam logic [2:0] OP_LOAD_Q   = 3'd0;
    localparam logic [2:0] OP_LOAD_K   = 3'd1;
    localparam logic [2:0] OP_KLOAD    = 3'd2;
    localparam logic [2:0] OP_EXEC     = 3'd3;
    localparam logic [2:0] OP_DRAIN    = 3'd4;
    localparam logic [2:0] OP_NORM_ACC = 3'd5;
    localparam logic [2:0] OP_NORM_DIV = 3'd6;
    localparam logic [2:0] OP_RSVD     = 3'd7;

    localparam int INST_VPROD     = 19;
    localparam int INST_DIV       = 18;
    localparam int INST_ACC       = 17;
    localparam int INST_OFIFO_RD  = 16;
    localparam int INST_QKADD_LSB = 12;
    localparam int INST_PADD_LSB  = 8;
    localparam int INST_MAC_LSB   = 6;
    localparam int INST_QMEM_RD   = 5;
    localparam int INST_QMEM_WR   = 4;
    localparam int INST_KMEM_RD   = 3;
    localparam int INST_KMEM_WR   = 2;
    localparam int INST_PMEM_RD   = 1;
    localparam int INST_PMEM_WR   = 0;

    localparam logic [1:0] MAC_IDLE  = 2'b00;
    localparam logic [1:0] MAC_KLOAD = 2'b10;
    localparam logic [1:0] MAC_EXEC  = 2'b01;

    // Fields that appear one cycle after the SRAM/OFIFO strobe that feeds them.
    typedef struct packed {
        logic [1:0]            mac;
        logic                  sfp_acc;
        logic                  sfp_div;
        logic                  pmem_wr;
        logic [INST_ADD_W-1:0] pmem_add;
    } dly_t;

    function automatic logic [INST_ADD_W-1:0] wrap_addr(input int base, input int idx, input int depth);
        return INST_ADD_W'((base + idx) % depth);
    endfunction

endpackage

// File: rtl/core_inst_seq_inst_pipe.sv
// One-stage register that delays the t+1 instruction fields behind their strobes.
module inst_pipe
    import core_pkg::*;
(
    input  logic clk,
    input  logic clr_i,
    input  dly_t d_i,
    output dly_t q_o
);

    dly_t pipe_q;

    always_ff @(posedge clk) begin
        // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
        if (clr_i) pipe_q <= '0;
        else       pipe_q <= d_i;
    end

    assign q_o = pipe_q;

endmodule

// File: rtl/core_inst_seq.sv
// Command sequencer: expands one accepted command into per-cycle SRAM, MAC, OFIFO and
// SFP strobes on the 20-bit inst bus, with read-latency-aligned delayed fields.
module core_inst_seq
    import core_pkg::*;
#(
    parameter  int QK_DEPTH = 16,
    parameter  int P_DEPTH  = 16,
    parameter  int LEN_W    = 5,
    localparam int QK_AW    = $clog2(QK_DEPTH),
    localparam int P_AW     = $clog2(P_DEPTH),
    localparam int BASE_W   = (QK_AW > P_AW) ? QK_AW : P_AW
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [BASE_W-1:0] cmd_base,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              cmd_vprod,
    input  logic              ofifo_valid,
    output logic              in_req,
    output logic [INST_W-1:0] inst,
    output logic              busy,
    output logic              done,
    output logic              err
);

    if (QK_DEPTH < 2 || QK_DEPTH > 2**INST_ADD_W || P_DEPTH < 2 || P_DEPTH > 2**INST_ADD_W) begin : g_depth_check
        $error("core_inst_seq: QK_DEPTH and P_DEPTH must lie in 2..16 to fit the inst address fields");
    end

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_TAIL  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]            state_q, state_d;
    logic [LEN_W-1:0]      cnt_q, cnt_d;
    logic [2:0]            op_q, op_d;
    logic [BASE_W-1:0]     base_q, base_d;
    logic [LEN_W-1:0]      len_q, len_d;
    logic                  vprod_q, vprod_d;
    logic                  err_q, err_d;
    logic [INST_W-1:0]     imm_q, imm_d;
    logic                  in_req_q, in_req_d;
    logic [INST_ADD_W-1:0] drain_add_q, drain_add_d;
    logic                  vprod_out_q, busy_q, done_q;

    logic                  issue;
    logic [2:0]            beat_op;
    logic [BASE_W-1:0]     beat_base;
    logic [LEN_W-1:0]      beat_idx;
    logic [INST_ADD_W-1:0] qk_addr, p_addr;
    dly_t                  pipe_d, pipe_q;

    // The beat decided in this cycle becomes visible after the next edge, so a DRAIN
    // beat is issued when ofifo_valid is seen high in the cycle before its ofifo_rd.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        base_d    = base_q;
        len_d     = len_q;
        vprod_d   = vprod_q;
        err_d     = err_q;
        issue     = 1'b0;
        beat_op   = op_q;
        beat_base = base_q;
        beat_idx  = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    op_d      = cmd_op;
                    base_d    = cmd_base;
                    len_d     = cmd_len;
                    vprod_d   = cmd_vprod;
                    err_d     = 1'b0;
                    cnt_d     = '0;
                    beat_op   = cmd_op;
                    beat_base = cmd_base;
                    beat_idx  = '0;
                    if (cmd_op == OP_RSVD) begin
                        state_d = S_DONE;
                        err_d   = 1'b1;
                    end else if (cmd_len == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ISSUE;
                        issue   = (cmd_op != OP_DRAIN) || ofifo_valid;
                    end
                end
            end
            S_ISSUE: begin
                if (cnt_q == len_q) state_d = S_TAIL;
                else                issue   = (op_q != OP_DRAIN) || ofifo_valid;
            end
            S_TAIL:  state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
        if (issue) cnt_d = beat_idx + LEN_W'(1);
    end

    always_comb begin
        imm_d       = '0;
        in_req_d    = 1'b0;
        drain_add_d = '0;
        qk_addr     = wrap_addr(int'(beat_base[QK_AW-1:0]), int'(beat_idx), QK_DEPTH);
        p_addr      = wrap_addr(int'(beat_base[P_AW-1:0]), int'(beat_idx), P_DEPTH);
        if (issue) begin
            case (beat_op)
                OP_LOAD_Q: begin
                    imm_d[INST_QMEM_WR]                   = 1'b1;
                    imm_d[INST_QKADD_LSB +: INST_ADD_W]   = qk_addr;
                    in_req_d                              = 1'b1;
                end
                OP_LOAD_K: begin
                    imm_d[INST_KMEM_WR]                   = 1'b1;
                    imm_d[INST_QKADD_LSB +: INST_ADD_W]   = qk_addr;
                    in_req_d                              = 1'b1;
                end
                OP_KLOAD: begin
                    imm_d[INST_KMEM_RD]                   = 1'b1;
                    imm_d[INST_QKADD_LSB +: INST_ADD_W]   = qk_addr;
                end
                OP_EXEC: begin
                    imm_d[INST_QMEM_RD]                   = 1'b1;
                    imm_d[INST_QKADD_LSB +: INST_ADD_W]   = qk_addr;
                end
                OP_DRAIN: begin
                    imm_d[INST_OFIFO_RD]                  = 1'b1;
                    drain_add_d                           = p_addr;
                end
                OP_NORM_ACC, OP_NORM_DIV: begin
                    imm_d[INST_PMEM_RD]                   = 1'b1;
                    imm_d[INST_PADD_LSB +: INST_ADD_W]    = p_addr;
                end
                default: ;
            endcase
        end
    end

    // Delayed fields are derived from the strobes currently on the bus.
    always_comb begin
        pipe_d = '0;
        if (imm_q[INST_KMEM_RD])      pipe_d.mac = MAC_KLOAD;
        else if (imm_q[INST_QMEM_RD]) pipe_d.mac = MAC_EXEC;
        pipe_d.sfp_acc  = imm_q[INST_PMEM_RD] && (op_q == OP_NORM_ACC);
        pipe_d.sfp_div  = imm_q[INST_PMEM_RD] && (op_q == OP_NORM_DIV);
        pipe_d.pmem_wr  = imm_q[INST_OFIFO_RD];
        pipe_d.pmem_add = drain_add_q;
    end

    inst_pipe u_pipe (
        .clk   (clk),
        .clr_i (reset),
        .d_i   (pipe_d),
        .q_o   (pipe_q)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            imm_q       <= '0;
            in_req_q    <= 1'b0;
            drain_add_q <= '0;
            vprod_out_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            imm_q       <= imm_d;
            in_req_q    <= in_req_d;
            drain_add_q <= drain_add_d;
            vprod_out_q <= (state_d != S_IDLE) && vprod_d;
            busy_q      <= (state_d != S_IDLE);
            done_q      <= (state_d == S_DONE);
        end
    end

    // NOTE: command payload registers carry no reset; they are always loaded at accept before use.
    always_ff @(posedge clk) begin
        op_q    <= op_d;
        base_q  <= base_d;
        len_q   <= len_d;
        vprod_q <= vprod_d;
    end

    always_comb begin
        inst                                    = imm_q;
        inst[INST_VPROD]                        = vprod_out_q;
        inst[INST_DIV]                          = pipe_q.sfp_div;
        inst[INST_ACC]                          = pipe_q.sfp_acc;
        inst[INST_MAC_LSB +: 2]                 = pipe_q.mac;
        inst[INST_PMEM_WR]                      = pipe_q.pmem_wr;
        inst[INST_PADD_LSB +: INST_ADD_W]       = imm_q[INST_PADD_LSB +: INST_ADD_W] | pipe_q.pmem_add;
    end

    assign cmd_ready = (state_q == S_IDLE) && !reset;
    assign in_req    = in_req_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_core_inst_seq.sv
// Self-checking bench for core_inst_seq: directed scenarios plus random commands, each
// compared cycle by cycle against a per-command expected-output table built from the rules.
module tb_core_inst_seq;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [3:0]  cmd_base;
    logic [4:0]  cmd_len;
    logic        cmd_vprod;
    logic        ofifo_valid;
    logic        in_req;
    logic [19:0] inst;
    logic        busy;
    logic        done;
    logic        err;

    int total = 0;
    int bad   = 0;
    logic err_exp = 1'b0;

    always #5 clk = ~clk;

    core_inst_seq #(.QK_DEPTH(16), .P_DEPTH(16), .LEN_W(5)) dut (
        .clk         (clk),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_base    (cmd_base),
        .cmd_len     (cmd_len),
        .cmd_vprod   (cmd_vprod),
        .ofifo_valid (ofifo_valid),
        .in_req      (in_req),
        .inst        (inst),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic pat_bit(input logic [63:0] pat, input int d);
        return (d < 64) ? pat[d] : 1'b1;
    endfunction

    // Accept one command in the current cycle and check every cycle until the idle cycle after done.
    task automatic run_cmd(input string name, input logic [2:0] op, input logic [3:0] base,
                           input logic [4:0] len, input logic vp, input logic [63:0] pat, input bit noise);
        logic [19:0] e_inst [128];
        logic        e_req  [128];
        int          d, i, t, a, done_rel;
        for (int k = 0; k < 128; k++) begin
            e_inst[k] = '0;
            e_req[k]  = 1'b0;
        end
        i = 0;
        d = 0;
        if (op == 3'd7 || len == 5'd0) begin
            done_rel = 1;
        end else begin
            while (i < int'(len)) begin
                if (op != 3'd4 || pat_bit(pat, d)) begin
                    t = d + 1;
                    a = (int'(base) + i) % DEPTH;
                    case (op)
                        3'd0: begin e_inst[t][4] = 1'b1; e_inst[t][15:12] = 4'(a); e_req[t] = 1'b1; end
                        3'd1: begin e_inst[t][2] = 1'b1; e_inst[t][15:12] = 4'(a); e_req[t] = 1'b1; end
                        3'd2: begin e_inst[t][3] = 1'b1; e_inst[t][15:12] = 4'(a); e_inst[t+1][7:6] = 2'b10; end
                        3'd3: begin e_inst[t][5] = 1'b1; e_inst[t][15:12] = 4'(a); e_inst[t+1][7:6] = 2'b01; end
                        3'd4: begin e_inst[t][16] = 1'b1; e_inst[t+1][0] = 1'b1; e_inst[t+1][11:8] = 4'(a); end
                        3'd5: begin e_inst[t][1] = 1'b1; e_inst[t][11:8] = 4'(a); e_inst[t+1][17] = 1'b1; end
                        default: begin e_inst[t][1] = 1'b1; e_inst[t][11:8] = 4'(a); e_inst[t+1][18] = 1'b1; end
                    endcase
                    i++;
                end
                d++;
            end
            done_rel = d + 2;
        end
        for (int r = 1; r <= done_rel; r++) e_inst[r][19] = vp;

        check($sformatf("%s ready_at_accept", name), cmd_ready, 1);
        check($sformatf("%s err_before_accept", name), err, err_exp);
        cmd_valid   = 1'b1;
        cmd_op      = op;
        cmd_base    = base;
        cmd_len     = len;
        cmd_vprod   = vp;
        ofifo_valid = pat_bit(pat, 0);
        tick();
        err_exp = (op == 3'd7);
        for (int r = 1; r <= done_rel; r++) begin
            check($sformatf("%s inst r=%0d", name, r), inst, e_inst[r]);
            check($sformatf("%s in_req r=%0d", name, r), in_req, e_req[r]);
            check($sformatf("%s busy r=%0d", name, r), busy, 1);
            check($sformatf("%s done r=%0d", name, r), done, (r == done_rel));
            check($sformatf("%s err r=%0d", name, r), err, err_exp);
            check($sformatf("%s ready r=%0d", name, r), cmd_ready, 0);
            cmd_valid   = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            cmd_op      = 3'($urandom);
            cmd_base    = 4'($urandom);
            cmd_len     = 5'($urandom);
            cmd_vprod   = 1'($urandom);
            ofifo_valid = pat_bit(pat, r);
            tick();
        end
        cmd_valid = 1'b0;
        check($sformatf("%s idle inst", name), inst, 0);
        check($sformatf("%s idle busy", name), busy, 0);
        check($sformatf("%s idle done", name), done, 0);
        check($sformatf("%s idle err", name), err, err_exp);
    endtask

    task automatic reset_mid_exec();
        cmd_valid = 1'b1;
        cmd_op    = 3'd3;
        cmd_base  = 4'd2;
        cmd_len   = 5'd8;
        cmd_vprod = 1'b1;
        tick();
        cmd_valid = 1'b0;
        for (int r = 1; r <= 4; r++) begin
            check($sformatf("t6 qmem_rd r=%0d", r), inst[5], 1);
            check($sformatf("t6 qkmem_add r=%0d", r), inst[15:12], 4'(2 + r - 1));
            check($sformatf("t6 busy r=%0d", r), busy, 1);
            if (r < 4) tick();
        end
        reset = 1'b1;
        #1;
        check("t6 ready_in_reset", cmd_ready, 0);
        tick();
        check("t6 inst_after_reset", inst, 0);
        check("t6 busy_after_reset", busy, 0);
        check("t6 done_after_reset", done, 0);
        check("t6 in_req_after_reset", in_req, 0);
        reset = 1'b0;
        #1;
        check("t6 ready_after_release", cmd_ready, 1);
        for (int r = 0; r < 12; r++) begin
            tick();
            check($sformatf("t6 no_done c=%0d", r), done, 0);
            check($sformatf("t6 quiet_inst c=%0d", r), inst, 0);
        end
        err_exp = 1'b0;
    endtask

    initial begin
        logic [2:0]  op;
        logic [4:0]  len;
        logic [63:0] pat;
        reset       = 1'b1;
        cmd_valid   = 1'b0;
        cmd_op      = '0;
        cmd_base    = '0;
        cmd_len     = '0;
        cmd_vprod   = 1'b0;
        ofifo_valid = 1'b0;
        tick();
        tick();
        check("reset inst", inst, 0);
        check("reset in_req", in_req, 0);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset err", err, 0);
        check("reset ready", cmd_ready, 0);
        reset = 1'b0;
        tick();

        run_cmd("t1_load_q", 3'd0, 4'd3, 5'd4, 1'b0, '1, 1'b0);
        run_cmd("t2_load_k", 3'd1, 4'd14, 5'd4, 1'b0, '1, 1'b1);
        run_cmd("t3_exec", 3'd3, 4'(10), 5'd8, 1'b1, '1, 1'b1);
        run_cmd("t4_drain", 3'd4, 4'd0, 5'd3, 1'b0, 64'h19, 1'b0);
        run_cmd("kload_wrap", 3'd2, 4'd13, 5'd5, 1'b1, '1, 1'b1);
        run_cmd("norm_acc", 3'd5, 4'd15, 5'd3, 1'b0, '1, 1'b1);
        run_cmd("norm_div", 3'd6, 4'd7, 5'd2, 1'b1, '1, 1'b0);
        run_cmd("t5_len0", 3'd3, 4'd5, 5'd0, 1'b0, '1, 1'b0);
        run_cmd("t5_rsvd", 3'd7, 4'd2, 5'd9, 1'b0, '1, 1'b1);
        tick();
        check("t5 err_sticky_idle", err, 1);
        run_cmd("t5_clear", 3'd5, 4'd1, 5'd3, 1'b0, '1, 1'b0);
        run_cmd("max_len", 3'd0, 4'd9, 5'd31, 1'b1, '1, 1'b1);

        for (int n = 0; n < 24; n++) begin
            op  = 3'($urandom_range(0, 7));
            len = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 2)) : 5'($urandom_range(1, 31));
            pat = {$urandom, $urandom};
            if ($urandom_range(0, 1) == 1) pat = pat | {$urandom, $urandom};
            run_cmd($sformatf("rand%0d_op%0d", n, op), op, 4'($urandom), len, 1'($urandom), pat, 1'b1);
        end

        reset_mid_exec();
        run_cmd("post_reset_exec", 3'd3, 4'd0, 5'd2, 1'b0, '1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
